// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_WAIT = 2'd1,
      M_ERR  = 2'd2
   } mem_state_e;

   // MEM wins over WB so the youngest producer is forwarded; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                          input logic [REG_W-1:0] rd_m,
                                          input logic [REG_W-1:0] rd_w,
                                          input logic             we_m,
                                          input logic             we_w);
      if (we_m && (rd_m != '0) && (rd_m == rs))      return FWD_MEM;
      else if (we_w && (rd_w != '0) && (rd_w == rs)) return FWD_WB;
      else                                           return FWD_RF;
   endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state tracker: counts consecutive not-ready cycles and
// latches a sticky timeout error that freezes the pipeline until cleared.
module mem_wait_fsm
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_req_i,
   input  logic mem_ready_i,
   input  logic clear_err_i,
   output logic in_err_o,
   output logic mem_err_o
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   mem_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         M_IDLE: begin
            if (mem_req_i && !mem_ready_i) begin
               state_d = M_WAIT;
               cnt_d   = CW'(1);
            end
         end
         M_WAIT: begin
            // A dropped request is an abort, not a timeout.
            if (mem_ready_i || !mem_req_i) begin
               state_d = M_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
               state_d = M_ERR;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         M_ERR: begin
            if (clear_err_i) begin
               state_d = M_IDLE;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = M_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= M_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign in_err_o  = (state_q == M_ERR);
   assign mem_err_o = err_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: forwarding selects, stall/flush enables
// with memory > load-use > branch priority, and a stall-cycle counter.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] Rs1D,
   input  logic [REG_W-1:0] Rs2D,
   input  logic [REG_W-1:0] Rs1E,
   input  logic [REG_W-1:0] Rs2E,
   input  logic [REG_W-1:0] RdE,
   input  logic [REG_W-1:0] RdM,
   input  logic [REG_W-1:0] RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic             ClearErr,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCount
);

   logic             in_err;
   logic             lw_stall, mem_stall;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk         (clk),
      .rst_n       (reset),
      .mem_req_i   (MemReqM),
      .mem_ready_i (MemReadyM),
      .clear_err_i (ClearErr),
      .in_err_o    (in_err),
      .mem_err_o   (MemErr)
   );

   assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
   assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

   // A taken branch squashes the ID instruction, so its load-use hazard is moot.
   assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
   assign mem_stall = (MemReqM && !MemReadyM) || in_err;

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (mem_stall) begin
         // MEM/WB bubble keeps the held MEM instruction from committing twice.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end
   end

   assign stall_cnt_d = StallF ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign StallCount = stall_cnt_q;

endmodule
